// File: rtl/ntt_result_unloader.sv
// ntt_result_unloader
//
// Read-side partner of the coefficient loader in the NTT/INTT test wrapper.
// On a start pulse (normally the core's done) it sweeps the coefficient RAM
// from address 0 to DEPTH-1 through one read port. Each 132-bit word goes out
// zero-extended to OUT_W bits on a valid/ready stream with full backpressure.
// A head register plus a 2-entry FIFO hides the 1-cycle RAM read latency, so
// with the sink always ready the stream runs one word per cycle with no gaps.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous, active-high reset
//   start      : one-cycle pulse that begins an unload (ignored while busy)
//   ram_rd_en  : RAM read request (registered)
//   ram_addr   : RAM read address (registered, holds while ram_rd_en=0)
//   ram_dout   : RAM read data, valid the cycle after ram_rd_en
//   dout       : output word {zeros, ram word}
//   dout_valid : dout holds a word
//   dout_ready : sink accepts the word this cycle
//   dout_last  : dout holds word DEPTH-1
//   busy       : unload in progress
//   done       : one-cycle pulse after the last word has been transferred

module ntt_result_unloader #(
  parameter int DATA_W = 132,
  parameter int OUT_W  = 136,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W:0]   LAST_RD  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_OUT = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W-1:0] out_count;
  logic              push_pending;
  logic [DATA_W-1:0] head_word;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [1:0]        fcnt;

  logic              pop;
  logic [2:0]        held;
  logic [2:0]        inflight;
  logic [2:0]        net;
  logic              credit_ok;
  logic              start_accept;
  logic              issue;
  logic              last_xfer;
  logic              load_head;
  logic              take_fifo;
  logic              take_push;
  logic              fifo_push;
  logic [1:0]        fcnt_mid;
  logic [DATA_W-1:0] q0_next;
  logic [DATA_W-1:0] q1_next;
  logic [1:0]        fcnt_next;

  assign dout      = {{(OUT_W - DATA_W){1'b0}}, head_word};
  assign dout_last = dout_valid && (out_count == LAST_OUT);
  assign busy      = (state != S_IDLE);

  // Read credit: 'net' is what will be held or still in the RAM pipe once this
  // cycle's transfer (if any) is gone. Total storage is the head register plus
  // two FIFO slots, so a new read is safe whenever net <= 2. We only use the
  // third slot while the sink is ready: a stalled sink then queues at most two
  // words, while a ready sink keeps the three-deep pipe full for gap-free rate.
  always_comb begin
    pop          = dout_valid && dout_ready;
    held         = 3'(dout_valid) + 3'(fcnt);
    inflight     = 3'(ram_rd_en) + 3'(push_pending);
    net          = held + inflight - 3'(pop);
    credit_ok    = net < (3'd2 + 3'(dout_ready));
    start_accept = (state == S_IDLE) && start;
    issue        = start_accept || ((state == S_READ) && credit_ok);
    last_xfer    = pop && (out_count == LAST_OUT);
  end

  // Buffer steering: the head register refills when it is empty or being
  // consumed, preferring the oldest FIFO entry and otherwise taking the RAM
  // word straight through. Anything arriving that the head cannot take is
  // appended behind whatever stays in the FIFO.
  always_comb begin
    load_head = !dout_valid || pop;
    take_fifo = load_head && (fcnt != 2'd0);
    take_push = load_head && (fcnt == 2'd0) && push_pending;
    fifo_push = push_pending && !take_push;
    fcnt_mid  = fcnt - 2'(take_fifo);
    q0_next   = take_fifo ? q1 : q0;
    q1_next   = q1;
    if (fifo_push) begin
      if (fcnt_mid == 2'd0) begin
        q0_next = ram_dout;
      end else begin
        q1_next = ram_dout;
      end
    end
    fcnt_next = fcnt_mid + 2'(fifo_push);
  end

  // Control: state machine, read address generation, the one-cycle delayed
  // copy of ram_rd_en that marks when RAM data is valid, the transfer counter
  // behind dout_last, and the done pulse one cycle after the final transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rd_idx       <= '0;
      ram_rd_en    <= 1'b0;
      ram_addr     <= '0;
      push_pending <= 1'b0;
      out_count    <= '0;
      done         <= 1'b0;
    end else begin
      ram_rd_en    <= issue;
      push_pending <= ram_rd_en;
      done         <= last_xfer;

      if (issue) begin
        ram_addr <= start_accept ? '0 : rd_idx[ADDR_W-1:0];
        rd_idx   <= start_accept ? (ADDR_W + 1)'(1) : rd_idx + 1'b1;
      end

      if (last_xfer) begin
        out_count <= '0;
      end else if (pop) begin
        out_count <= out_count + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= (DEPTH == 1) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (issue && (rd_idx == LAST_RD)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_xfer) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: head register (what dout shows) and the two FIFO slots behind
  // it. Reset empties everything, which also discards a read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_word  <= '0;
      dout_valid <= 1'b0;
      q0         <= '0;
      q1         <= '0;
      fcnt       <= 2'd0;
    end else begin
      if (load_head) begin
        if (take_fifo) begin
          head_word  <= q0;
          dout_valid <= 1'b1;
        end else if (take_push) begin
          head_word  <= ram_dout;
          dout_valid <= 1'b1;
        end else begin
          dout_valid <= 1'b0;
        end
      end
      q0   <= q0_next;
      q1   <= q1_next;
      fcnt <= fcnt_next;
    end
  end

  // The read credit must make an arriving word always find room.
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && (fcnt_mid == 2'd2)));
  assert property (@(posedge clk) disable iff (rst) fcnt <= 2'd2);

endmodule

// File: tb/tb_ntt_result_unloader.sv
// tb_ntt_result_unloader
//
// Directed bench for ntt_result_unloader. A behavioural synchronous RAM feeds
// the unloader with known words; each unload run is stepped cycle by cycle and
// the read addresses, output words, dout_last, stall stability, done timing
// and latency are compared against values computed here.
//
// Ports: none (top-level bench).

module tb_ntt_result_unloader;

  localparam int DATA_W = 132;
  localparam int OUT_W  = 136;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              dout_last;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  ntt_result_unloader #(
    .DATA_W(DATA_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Word i of the coefficient RAM: i * 0x1_0000_0001 with a marker in the top
  // lane nibble so the upper RAM bits and the zero extension are both visible.
  function automatic logic [DATA_W-1:0] ram_word(input int i);
    logic [DATA_W-1:0] w;
    w = DATA_W'(i) * 132'h1_0000_0001;
    w[DATA_W-1:DATA_W-4] = 4'(i) ^ 4'hA;
    return w;
  endfunction

  function automatic logic [OUT_W-1:0] exp_dout(input int i);
    return {4'h0, ram_word(i)};
  endfunction

  function automatic logic [159:0] outs_now();
    return 160'({ram_rd_en, ram_addr, dout, dout_valid, dout_last, busy, done});
  endfunction

  // Synchronous-read RAM model: data appears the cycle after ram_rd_en.
  always @(posedge clk) begin
    if (ram_rd_en) ram_dout <= ram_word(int'(ram_addr));
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [159:0] actual,
                             input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles, check outputs while held, then release.
  task automatic applyReset();
    rst        = 1'b1;
    start      = 1'b0;
    dout_ready = 1'b0;
    repeat (2) step();
    checkOutput("outputs_in_reset", outs_now(), '0);
    rst = 1'b0;
    step();
  endtask

  // One unload run. mode 0: sink always ready (latency checked),
  // 1: LFSR backpressure, 2: sink stalled through T+30, 3: second start at
  // T+10, 4: sink always ready and a new start in the done cycle.
  task automatic applyStimulus(input int mode);
    int            rel = 0;
    int            idx = 0;
    int            exp_addr = 0;
    int            reads = 0;
    int            early_reads = 0;
    int            done_count = 0;
    int            done_rel = -1;
    int            last_rel = -1;
    logic          was_stalled = 1'b0;
    logic [136:0]  held = '0;
    logic [15:0]   lfsr = 16'hACE1;

    while (rel < 400) begin
      if (done_rel >= 0 && rel > done_rel + 3) break;

      if (ram_rd_en) begin
        reads++;
        if (rel <= 31) early_reads++;
        if (exp_addr < DEPTH) begin
          checkOutput("read_addr", 160'(ram_addr), 160'(exp_addr));
          exp_addr++;
        end
      end
      if (mode == 0 && rel == 1)
        checkOutput("first_read", 160'({ram_rd_en, ram_addr}), 160'({1'b1, 6'd0}));
      if (done) begin
        done_count++;
        if (done_rel < 0) done_rel = rel;
        checkOutput("busy_low_at_done", 160'(busy), 160'(0));
      end
      if (mode == 4 && done_rel >= 0 && rel == done_rel + 1)
        checkOutput("restart_read", 160'({busy, ram_rd_en, ram_addr}), 160'({2'b11, 6'd0}));

      start = (rel == 0) || (mode == 3 && rel == 10) || (mode == 4 && done && rel == done_rel);
      case (mode)
        1:       dout_ready = lfsr[0];
        2:       dout_ready = (rel > 30);
        default: dout_ready = 1'b1;
      endcase

      if (dout_valid && was_stalled)
        checkOutput("stall_hold", 160'({dout_last, dout}), 160'(held));
      if (dout_valid && idx < DEPTH) begin
        checkOutput("last_flag", 160'(dout_last), 160'(idx == DEPTH - 1));
        if (dout_ready) begin
          checkOutput("word", 160'(dout), 160'(exp_dout(idx)));
          if (mode == 0) checkOutput("word_latency", 160'(rel), 160'(3 + idx));
          if (idx == DEPTH - 1) last_rel = rel;
          idx++;
        end
      end
      was_stalled = dout_valid && !dout_ready;
      held        = {dout_last, dout};

      step();
      rel++;
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    start      = 1'b0;
    dout_ready = 1'b0;
    checkOutput("word_count", 160'(idx), 160'(DEPTH));
    checkOutput("addr_count", 160'(exp_addr), 160'(DEPTH));
    checkOutput("done_pulses", 160'(done_count), 160'(1));
    checkOutput("done_after_last", 160'(done_rel), 160'(last_rel + 1));
    if (mode != 4) checkOutput("read_total", 160'(reads), 160'(DEPTH));
    if (mode == 2) checkOutput("reads_during_stall", 160'(early_reads <= 2), 160'(1));
  endtask

  initial begin
    int idle_reads;

    applyReset();
    checkOutput("idle_after_reset", outs_now(), '0);
    idle_reads = 0;
    for (int i = 0; i < 20; i++) begin
      if (ram_rd_en) idle_reads++;
      step();
    end
    checkOutput("idle_no_reads", 160'(idle_reads), 160'(0));

    applyStimulus(0);
    step();
    applyStimulus(1);
    step();
    applyStimulus(2);
    step();
    applyStimulus(3);
    step();

    // Reset in the middle of a run, while word 20 sits on dout.
    start      = 1'b1;
    dout_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (22) step();
    checkOutput("pre_reset_word", 160'(dout), 160'(exp_dout(20)));
    #2 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", outs_now(), '0);
    dout_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    checkOutput("after_mid_reset", outs_now(), '0);
    applyStimulus(0);
    step();

    applyStimulus(4);
    applyReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
